// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter through a one-cycle start pulse and a busy handshake.
// Define UART_TX_FIFO_OVF_EN to add the overflow flag/counter ports (ovf_o, ovf_cnt_o).
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic [7:0]          tx_data_o,
  output logic                tx_en_o,
  input  logic                tx_busy_i,
  output logic [DEPTH_LOG2:0] fifo_level_o,
  output logic                fifo_empty_o,
  output logic                fifo_full_o
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                ovf_o,
  output logic [7:0]          ovf_cnt_o
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [7:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_reg;
  logic [DEPTH_LOG2-1:0]   rd_ptr_reg;
  logic [DEPTH_LOG2:0]     level_reg;
  logic [7:0]              tx_data_reg;
  logic                    tx_en_reg;
  logic                    push;
  logic                    pop;

  assign fifo_level_o = level_reg;
  assign fifo_empty_o = (level_reg == '0);
  assign fifo_full_o  = (level_reg == LEVEL_FULL);
  assign s_ready_o    = !fifo_full_o;
  assign push         = s_valid_i && s_ready_o;
  assign tx_data_o    = tx_data_reg;
  assign tx_en_o      = tx_en_reg;

  // Storage carries no reset so it maps onto block RAM; level alone decides validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        level_reg <= level_reg + 1'b1;
      end else if (pop && !push) begin
        level_reg <= level_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty_o && !tx_busy_i) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD:      state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          state_next = IDLE;
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  // The data register only changes on a pop, so it holds for the whole frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_data_reg <= 8'h00;
      tx_en_reg   <= 1'b0;
    end else begin
      tx_en_reg <= (state_next == START);
      if (pop) begin
        tx_data_reg <= mem[rd_ptr_reg];
      end
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf_reg;
  logic [7:0] ovf_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_reg     <= 1'b0;
      ovf_cnt_reg <= 8'h00;
    end else if (s_valid_i && fifo_full_o) begin
      ovf_reg <= 1'b1;
      if (ovf_cnt_reg != 8'hFF) begin
        ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
      end
    end
  end

  assign ovf_o     = ovf_reg;
  assign ovf_cnt_o = ovf_cnt_reg;
`else
  // Pushes against a full FIFO are dropped without any record.
`endif

  a_tx_en_single: assert property (@(posedge clk_i) disable iff (rst_i) tx_en_o |=> !tx_en_o);
  a_level_range:  assert property (@(posedge clk_i) disable iff (rst_i) level_reg <= LEVEL_FULL);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a monitor checks each tx_en_o pulse.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_busy;
  logic [4:0] level;
  logic       empty;
  logic       full;
`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf;
  logic [7:0] ovf_cnt;
`endif

  logic       force_busy;
  logic       model_busy;
  int         bit_cycles;
  int         checks;
  int         errors;
  int         pulse_cnt;
  logic       prev_en;
  logic [7:0] exp_q[$];

  assign tx_busy = force_busy | model_busy;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .tx_data_o    (tx_data),
    .tx_en_o      (tx_en),
    .tx_busy_i    (tx_busy),
    .fifo_level_o (level),
    .fifo_empty_o (empty),
    .fifo_full_o  (full)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf_o        (ovf),
    .ovf_cnt_o    (ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every start pulse must carry the oldest queued byte.
  always @(negedge clk) begin
    if (!rst && tx_en) begin
      pulse_cnt++;
      check("tx_en_single", {31'd0, prev_en}, 32'd0);
      check("pulse_while_busy", {31'd0, tx_busy}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: data 0x%0h with empty scoreboard at %0t", tx_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("frame_data", {24'd0, tx_data}, {24'd0, e});
        $display("frame start: data 0x%02h expected 0x%02h at %0t", tx_data, e, $time);
      end
    end
    prev_en = tx_en;
  end

  // Transmitter model: busy one cycle after the pulse for 10 bit-times; data must hold throughout.
  initial begin
    logic [7:0] frame_data;
    logic       frame_ok;
    logic       frame_abort;
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && tx_en) begin
        frame_data  = tx_data;
        frame_ok    = 1'b1;
        frame_abort = 1'b0;
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (10 * bit_cycles) begin
          @(negedge clk);
          if (rst) frame_abort = 1'b1;
          else if (tx_data !== frame_data) frame_ok = 1'b0;
        end
        @(posedge clk);
        #1 model_busy = 1'b0;
        if (!frame_abort) check("frame_hold", {31'd0, frame_ok}, 32'd1);
      end
    end
  end

  task automatic push(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    exp_q.push_back(d);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic push_blocked(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    check("blocked_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    int quiet;
    n = 0;
    quiet = 0;
    while (quiet < 4 && n < limit) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && !tx_busy && level == 5'd0) quiet++;
      else quiet = 0;
    end
    check("drain_in_time", {31'd0, n < limit}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"}, {27'd0, level}, 32'd0);
    check({tag, "_empty"}, {31'd0, empty}, 32'd1);
    check({tag, "_full"}, {31'd0, full}, 32'd0);
    check({tag, "_ready"}, {31'd0, s_ready}, 32'd1);
    check({tag, "_tx_en"}, {31'd0, tx_en}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
  endtask

  initial begin
    int p0;
    checks = 0;
    errors = 0;
    pulse_cnt = 0;
    prev_en = 1'b0;
    bit_cycles = 1;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    force_busy = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_values("por");
`ifdef UART_TX_FIFO_OVF_EN
    check("por_ovf", {31'd0, ovf}, 32'd0);
    check("por_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
`endif
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single byte: level 1 then 0, pulse three cycles after acceptance.
    push(8'hA5);
    @(negedge clk);
    check("single_level_n1", {27'd0, level}, 32'd1);
    check("single_en_n1", {31'd0, tx_en}, 32'd0);
    @(negedge clk);
    check("single_level_n2", {27'd0, level}, 32'd0);
    check("single_en_n2", {31'd0, tx_en}, 32'd0);
    @(negedge clk);
    check("single_en_n3", {31'd0, tx_en}, 32'd1);
    @(negedge clk);
    check("single_en_n4", {31'd0, tx_en}, 32'd0);
    check("single_data_n4", {24'd0, tx_data}, 32'h0000_00A5);
    @(posedge clk);
    #1;
    wait_drain(500);

    // Fill with the transmitter held busy, then push against a full FIFO.
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    @(negedge clk);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_ready", {31'd0, s_ready}, 32'd0);
    check("fill_level", {27'd0, level}, 32'd16);
    check("fill_empty", {31'd0, empty}, 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
    check("fill_ovf_pre", {31'd0, ovf}, 32'd0);
`endif
    @(posedge clk);
    #1;
    push_blocked(8'hFF);
    @(negedge clk);
    check("blocked_level", {27'd0, level}, 32'd16);
    @(posedge clk);
    #1;
`ifdef UART_TX_FIFO_OVF_EN
    push_blocked(8'hFF);
    push_blocked(8'hFF);
    @(negedge clk);
    check("ovf_flag", {31'd0, ovf}, 32'd1);
    check("ovf_cnt_3", {24'd0, ovf_cnt}, 32'd3);
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) push_blocked(8'hFF);
    @(negedge clk);
    check("ovf_cnt_sat", {24'd0, ovf_cnt}, 32'hFF);
    @(posedge clk);
    #1;
`endif
    force_busy = 1'b0;
    wait_drain(2000);

    // Ordering through a 115200-bps transmitter at 100 MHz.
    bit_cycles = 868;
    p0 = pulse_cnt;
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    wait_drain(40000);
    check("order_pulses", 32'(pulse_cnt - p0), 32'd3);

    // Advance pointers to 13, then build level 3 across the 15->0 wrap.
    bit_cycles = 1;
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
    wait_drain(1000);
    force_busy = 1'b1;
    push(8'hE0);
    push(8'hE1);
    push(8'hE2);
    @(negedge clk);
    check("sim_level_pre", {27'd0, level}, 32'd3);
    @(posedge clk);
    #1;
    force_busy = 1'b0;
    push(8'hC0);
    @(negedge clk);
    check("sim_level_post", {27'd0, level}, 32'd3);
    @(posedge clk);
    #1;
    push(8'hC1);
    push(8'hC2);
    wait_drain(1000);

    // Reset during WAIT_DONE with five bytes stored.
    bit_cycles = 20;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    @(negedge clk);
    check("rst_level_pre", {27'd0, level}, 32'd5);
    check("rst_busy_pre", {31'd0, tx_busy}, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    p0 = pulse_cnt;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (300) @(negedge clk);
    check("rst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("rst_level_post", {27'd0, level}, 32'd0);
    check("rst_empty_post", {31'd0, empty}, 32'd1);
    @(posedge clk);
    #1;
    push(8'h3C);
    wait_drain(1000);
    check("rst_recover_pulse", 32'(pulse_cnt - p0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning FIFO depth = 2^DEPTH_LOG2 bytes (legal values 1..8).
REQ-002 SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port s_data_i  input  8  byte to transmit.
REQ-005 SHALL have port s_valid_i  input  1  s_data_i valid.
REQ-006 SHALL have port s_ready_o  output  1  FIFO can accept a byte this cycle.
REQ-007 SHALL have port tx_data_o  output  8  byte presented to the downstream UART transmitter.
REQ-008 SHALL have port tx_en_o  output  1  one-cycle start pulse to the transmitter.
REQ-009 SHALL have port tx_busy_i  input  1  transmitter frame in progress.
REQ-010 SHALL have port fifo_level_o  output  DEPTH_LOG2+1  stored byte count.
REQ-011 SHALL have ports fifo_empty_o and fifo_full_o  output  1 each  level==0 / level==2^DEPTH_LOG2.

Function
REQ-012 SHALL accept a byte on any cycle where s_valid_i && s_ready_o; s_ready_o = !fifo_full_o (combinational from registered state, no dependence on s_valid_i).
REQ-013 SHALL store bytes in first-in-first-out order; read/write pointers DEPTH_LOG2 bits, wrap from 2^DEPTH_LOG2-1 to 0.
REQ-014 SHALL keep level unchanged on a simultaneous push and pop; no bypass path (an accepted byte is visible to the pop logic one cycle later).
REQ-015 SHALL implement states IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE: if !fifo_empty_o && !tx_busy_i, pop head byte into tx_data_o register -> LOAD; else stay.
REQ-017 LOAD -> START unconditionally; START drives tx_en_o=1 for exactly that one cycle -> WAIT_BUSY.
REQ-018 WAIT_BUSY: on tx_busy_i=1 -> WAIT_DONE; else stay.
REQ-019 WAIT_DONE: on tx_busy_i=0 -> IDLE.
REQ-020 tx_data_o SHALL hold constant from LOAD until the state re-enters IDLE (downstream transmitter samples data throughout the frame).
REQ-021 Latency: byte accepted in cycle N into empty FIFO with state IDLE and tx_busy_i=0 SHALL produce tx_en_o=1 in cycle N+3.
REQ-022 tx_en_o SHALL be a registered output, never high two consecutive cycles.
REQ-023 Bytes accepted while full-blocked are not possible; s_valid_i with s_ready_o=0 SHALL leave FIFO contents unchanged.

Reset
REQ-024 rst_i SHALL asynchronously force: state IDLE, pointers 0, level 0, tx_data_o 8'h00, tx_en_o 0, fifo_empty_o 1, fifo_full_o 0, s_ready_o 1.
REQ-025 Reset mid-frame SHALL discard all stored bytes; after release, no tx_en_o until a new byte is accepted and tx_busy_i is low.

Configuration
REQ-026 Macro UART_TX_FIFO_OVF_EN defined: SHALL add output ovf_o (1 bit, sticky, set on any cycle with s_valid_i=1 && fifo_full_o=1, cleared only by rst_i) and output ovf_cnt_o (8 bits, increments on the same condition, saturates at 8'hFF, reset 0).
REQ-027 Macro UART_TX_FIFO_OVF_EN undefined: ports ovf_o and ovf_cnt_o SHALL not exist; dropped-push attempts are silently ignored.

Verification
REQ-028 Single byte: push 8'hA5 in cycle N, tx_busy_i model rises N+4 for 10 bit-times -> tx_en_o=1 only in N+3, tx_data_o=8'hA5 stable until busy falls, level 1 in N+1, 0 in N+2.
REQ-029 Fill: tx_busy_i held 1, DEPTH_LOG2=4, push 16 bytes 8'h00..8'h0F -> fifo_full_o=1, s_ready_o=0, fifo_level_o=16; 17th push 8'hFF ignored.
REQ-030 Ordering: push 8'h00, 8'hFF, 8'h55 back-to-back into a 115200-bps transmitter model at 100 MHz -> three frames in that order, exactly three tx_en_o pulses, each after previous busy fall.
REQ-031 Simultaneous push/pop: level 3, push in the cycle IDLE pops -> level stays 3, pointer wrap across entry 15->0 preserves order.
REQ-032 Reset mid-frame: assert rst_i during WAIT_DONE with level 5 -> all outputs at REQ-024 values within same cycle, no further tx_en_o.
REQ-033 With UART_TX_FIFO_OVF_EN: 3 pushes while full -> ovf_o=1, ovf_cnt_o=3; 300 pushes while full -> ovf_cnt_o=8'hFF.
